// File: rtl/ram_pkg.sv
// Shared constants, types and width helper for the byte-enable 1W/1R RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   RDW_READ_OLD / RDW_WRITE_FIRST : same-address read-during-write policies
//   ram_clr_state_t                : post-reset clear sequencer states
//   clog2s()                       : ceil(log2(n)) clamped to at least 1 bit
package ram_pkg;

  localparam int RDW_READ_OLD    = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_clr_state_t;

  // Address width that never collapses to zero bits for tiny depths.
  function automatic int clog2s(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every RAM address once writing zero, then RUN.
// Latency: one address per cycle; RDY is registered and rises the cycle after the last clear write.
// Backpressure: none; clearing cannot be stalled, user accesses are locked out until RUN.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   rdy       : registered "RAM accepts accesses"
//   clr_we    : clear write strobe (high for the whole CLEAR state)
//   clr_addr  : address being cleared this cycle
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int C_RAM_DEPTH    = 1024,
  parameter int C_CLEAR_ON_RST = 1,
  parameter int AW             = clog2s(C_RAM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          rdy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam ram_clr_state_t RST_STATE = (C_CLEAR_ON_RST != 0) ? CLEAR : RUN;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(C_RAM_DEPTH - 1);
  localparam logic           RST_RDY   = (C_CLEAR_ON_RST == 0);

  ram_clr_state_t state, state_nxt;
  logic [AW-1:0]  cnt, cnt_nxt;
  logic           rdy_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
      rdy   <= RST_RDY;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rdy   <= rdy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdy_nxt   = rdy;
    clr_we    = 1'b0;
    clr_addr  = cnt;
    case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        // The edge that writes the last word also raises RDY, so RDY is
        // seen high on the very next cycle.
        if (cnt == LAST_ADDR) begin
          state_nxt = RUN;
          rdy_nxt   = 1'b1;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        rdy_nxt = 1'b1;
      end
      default: begin
        state_nxt = RST_STATE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/ram_1clk_1w_1r_be.sv
// Single-clock 1W/1R RAM with byte enables, gated read, 1/2-cycle read latency, post-reset clear.
// Latency: write visible to a read issued the next cycle; read data C_RD_LATENCY cycles after REB.
// Backpressure: none while RDY=1 (one write and one read per cycle); WEA/REB ignored while RDY=0.
//
// Ports:
//   CLK, RST      : clock, asynchronous active-high reset (storage array is not reset)
//   RDY           : registered, high when accesses are accepted
//   WEA/ADDRA/BEA/DINA : write request, address, byte-lane enables, data
//   REB/ADDRB     : read request, address
//   DOUTB/VALIDB  : registered read data and its valid strobe
module ram_1clk_1w_1r_be
  import ram_pkg::*;
#(
  parameter  int C_RAM_WIDTH    = 32,
  parameter  int C_RAM_DEPTH    = 1024,
  parameter  int C_BYTE_WIDTH   = 8,
  parameter  int C_RD_LATENCY   = 1,
  parameter  int C_RDW_MODE     = 0,
  parameter  int C_CLEAR_ON_RST = 1,
  localparam int AW             = clog2s(C_RAM_DEPTH),
  localparam int NB             = C_RAM_WIDTH / C_BYTE_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   RDY,
  input  logic                   WEA,
  input  logic [AW-1:0]          ADDRA,
  input  logic [NB-1:0]          BEA,
  input  logic [C_RAM_WIDTH-1:0] DINA,
  input  logic                   REB,
  input  logic [AW-1:0]          ADDRB,
  output logic [C_RAM_WIDTH-1:0] DOUTB,
  output logic                   VALIDB
);

  if (C_RAM_WIDTH % C_BYTE_WIDTH != 0) begin : g_bad_width
    $error("C_RAM_WIDTH must be a multiple of C_BYTE_WIDTH");
  end
  if (C_RD_LATENCY != 1 && C_RD_LATENCY != 2) begin : g_bad_latency
    $error("C_RD_LATENCY must be 1 or 2");
  end
  if (C_RDW_MODE != RDW_READ_OLD && C_RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
    $error("C_RDW_MODE must be 0 or 1");
  end

  // One extra bit so a power-of-two depth still compares correctly.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(C_RAM_DEPTH);

  logic [C_RAM_WIDTH-1:0] mem [0:C_RAM_DEPTH-1];

  logic                   clr_we;
  logic [AW-1:0]          clr_addr;
  logic                   run;
  logic                   wr_hit;
  logic                   rd_en;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [NB-1:0]          mem_be;
  logic [C_RAM_WIDTH-1:0] mem_din;
  logic [C_RAM_WIDTH-1:0] rd_data;
  logic [C_RAM_WIDTH-1:0] s1_dat;
  logic                   s1_vld;

  ram_clear_seq #(
    .C_RAM_DEPTH    (C_RAM_DEPTH),
    .C_CLEAR_ON_RST (C_CLEAR_ON_RST),
    .AW             (AW)
  ) u_clear_seq (
    .clk      (CLK),
    .rst      (RST),
    .rdy      (RDY),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // The sequencer only strobes clr_we in CLEAR, so its inverse is RUN.
  assign run    = ~clr_we;
  assign wr_hit = run & WEA & ({1'b0, ADDRA} < DEPTH_W);
  assign rd_en  = run & REB;

  // Single physical write port shared between the clear walk and user writes.
  assign mem_we   = clr_we | wr_hit;
  assign mem_addr = clr_we ? clr_addr : ADDRA;
  assign mem_be   = clr_we ? {NB{1'b1}} : BEA;
  assign mem_din  = clr_we ? '0 : DINA;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][i*C_BYTE_WIDTH +: C_BYTE_WIDTH] <= mem_din[i*C_BYTE_WIDTH +: C_BYTE_WIDTH];
        end
      end
    end
  end

  // Array read sees pre-write contents; write-first mode overlays the lanes
  // being written in the same cycle at the same address.
  always_comb begin
    rd_data = mem[ADDRB];
    if (C_RDW_MODE == RDW_WRITE_FIRST && wr_hit && (ADDRA == ADDRB)) begin
      for (int i = 0; i < NB; i++) begin
        if (BEA[i]) begin
          rd_data[i*C_BYTE_WIDTH +: C_BYTE_WIDTH] = DINA[i*C_BYTE_WIDTH +: C_BYTE_WIDTH];
        end
      end
    end
  end

  // Stage 1 only loads on a read so DOUTB keeps the last result between reads.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_dat <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= rd_en;
      if (rd_en) begin
        s1_dat <= rd_data;
      end
    end
  end

  if (C_RD_LATENCY == 2) begin : g_lat2
    logic [C_RAM_WIDTH-1:0] s2_dat;
    logic                   s2_vld;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        s2_dat <= '0;
        s2_vld <= 1'b0;
      end else begin
        s2_dat <= s1_dat;
        s2_vld <= s1_vld;
      end
    end

    assign DOUTB  = s2_dat;
    assign VALIDB = s2_vld;
  end else begin : g_lat1
    assign DOUTB  = s1_dat;
    assign VALIDB = s1_vld;
  end

endmodule

// File: tb/tb_ram_1clk_1w_1r_be.sv
// Self-checking bench: two DUTs share inputs (latency 1 / read-old, latency 2 / write-first)
// and are compared each cycle against a word-array model with a read-result delay queue.
// Directed cases from the test plan are followed by randomized traffic and reset mid-clear.
module tb_ram_1clk_1w_1r_be;

  localparam int DEPTH = 1000;
  localparam int W     = 32;
  localparam int NB    = 4;
  localparam int AW    = 10;

  typedef struct {
    bit          v;
    bit          k;
    logic [31:0] d;
  } rd_t;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] addra;
  logic [NB-1:0] bea;
  logic [W-1:0]  dina;
  logic          reb;
  logic [AW-1:0] addrb;
  logic          rdy0, rdy1, valid0, valid1;
  logic [W-1:0]  dout0, dout1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] model [0:DEPTH-1];
  rd_t         q1[$];
  bit          x0_k, x1_k;
  logic [31:0] x0_d, x1_d;

  ram_1clk_1w_1r_be #(
    .C_RAM_WIDTH(W), .C_RAM_DEPTH(DEPTH), .C_BYTE_WIDTH(8),
    .C_RD_LATENCY(1), .C_RDW_MODE(0), .C_CLEAR_ON_RST(1)
  ) dut0 (
    .CLK(clk), .RST(rst), .RDY(rdy0), .WEA(we), .ADDRA(addra), .BEA(bea),
    .DINA(dina), .REB(reb), .ADDRB(addrb), .DOUTB(dout0), .VALIDB(valid0)
  );

  ram_1clk_1w_1r_be #(
    .C_RAM_WIDTH(W), .C_RAM_DEPTH(DEPTH), .C_BYTE_WIDTH(8),
    .C_RD_LATENCY(2), .C_RDW_MODE(1), .C_CLEAR_ON_RST(1)
  ) dut1 (
    .CLK(clk), .RST(rst), .RDY(rdy1), .WEA(we), .ADDRA(addra), .BEA(bea),
    .DINA(dina), .REB(reb), .ADDRB(addrb), .DOUTB(dout1), .VALIDB(valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    q1.delete();
    q1.push_back('{v: 1'b0, k: 1'b1, d: 32'h0});
    x0_k = 1'b1; x0_d = '0;
    x1_k = 1'b1; x1_d = '0;
  endtask

  task automatic idle();
    we = 1'b0; reb = 1'b0; bea = '0; dina = '0; addra = '0; addrb = '0;
  endtask

  // One RUN-state cycle: predict from current inputs, clock, then compare.
  task automatic tick();
    rd_t e0, e1, e;
    bit  acc;
    acc = we && (addra < DEPTH);
    e0 = '{v: reb, k: 1'b0, d: 32'h0};
    if (reb && (addrb < DEPTH)) begin
      e0.k = 1'b1;
      e0.d = model[addrb];
    end
    e1 = e0;
    if (e1.k && acc && (addra == addrb))
      for (int i = 0; i < NB; i++)
        if (bea[i]) e1.d[i*8 +: 8] = dina[i*8 +: 8];
    if (acc)
      for (int i = 0; i < NB; i++)
        if (bea[i]) model[addra][i*8 +: 8] = dina[i*8 +: 8];
    q1.push_back(e1);
    @(posedge clk); #1;
    if (e0.v) begin x0_k = e0.k; x0_d = e0.d; end
    chk("rdy0", {31'b0, rdy0}, 32'd1);
    chk("valid0", {31'b0, valid0}, {31'b0, e0.v});
    if (x0_k) chk("dout0", dout0, x0_d);
    e = q1.pop_front();
    if (e.v) begin x1_k = e.k; x1_d = e.d; end
    chk("rdy1", {31'b0, rdy1}, 32'd1);
    chk("valid1", {31'b0, valid1}, {31'b0, e.v});
    if (x1_k) chk("dout1", dout1, x1_d);
  endtask

  // Assert reset between edges and check outputs drop without waiting for a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rdy0", {31'b0, rdy0}, 32'd0);
    chk("rst_rdy1", {31'b0, rdy1}, 32'd0);
    chk("rst_valid0", {31'b0, valid0}, 32'd0);
    chk("rst_valid1", {31'b0, valid1}, 32'd0);
    chk("rst_dout0", dout0, 32'd0);
    chk("rst_dout1", dout1, 32'd0);
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Clock n cycles of the clear walk while hammering WEA/REB, which must be ignored.
  task automatic run_clear(input int n);
    we = 1'b1; dina = 32'hFFFF_FFFF; bea = 4'hF; reb = 1'b1;
    for (int k = 1; k <= n; k++) begin
      addra = AW'($urandom_range(0, DEPTH - 1));
      addrb = AW'($urandom_range(0, DEPTH - 1));
      @(posedge clk); #1;
      chk("clr_rdy0", {31'b0, rdy0}, {31'b0, (k >= DEPTH)});
      chk("clr_rdy1", {31'b0, rdy1}, {31'b0, (k >= DEPTH)});
      chk("clr_valid0", {31'b0, valid0}, 32'd0);
      chk("clr_valid1", {31'b0, valid1}, 32'd0);
    end
    chk("clr_dout0", dout0, 32'd0);
    chk("clr_dout1", dout1, 32'd0);
    if (n >= DEPTH)
      for (int a = 0; a < DEPTH; a++) model[a] = '0;
    idle();
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    idle();
    we = 1'b1; addra = AW'(a); dina = d; bea = be;
    tick();
    idle();
  endtask

  task automatic rd(input int a);
    idle();
    reb = 1'b1; addrb = AW'(a);
    tick();
    idle();
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    idle();
    rst = 1'b1;
    reset_model();
    @(posedge clk); #1;
    chk("init_rdy0", {31'b0, rdy0}, 32'd0);
    chk("init_valid1", {31'b0, valid1}, 32'd0);
    chk("init_dout0", dout0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Clear after reset: RDY on cycle DEPTH+1, contents zero.
    run_clear(DEPTH);
    rd(0); rd(500); rd(999);
    tick();
    chk("clr_rd999_dout1", dout1, 32'd0);

    // Byte-enable write.
    wr(5, 32'hAABB_CCDD, 4'b1111);
    wr(5, 32'h1122_3344, 4'b0101);
    rd(5);
    chk("be_dout0", dout0, 32'hAA22_CC44);
    tick();
    chk("be_dout1", dout1, 32'hAA22_CC44);

    // Latency-2 read pattern with a gap.
    wr(1, 32'h0101_0101, 4'hF);
    wr(2, 32'h0202_0202, 4'hF);
    wr(3, 32'h0303_0303, 4'hF);
    reb = 1'b1; addrb = AW'(1); tick();
    reb = 1'b1; addrb = AW'(2); tick();
    chk("lat_v_a1", {31'b0, valid1}, 32'd1);
    chk("lat_d_a1", dout1, 32'h0101_0101);
    reb = 1'b0; tick();
    chk("lat_d_a2", dout1, 32'h0202_0202);
    reb = 1'b1; addrb = AW'(3); tick();
    chk("lat_hold_v", {31'b0, valid1}, 32'd0);
    chk("lat_hold_d", dout1, 32'h0202_0202);
    reb = 1'b0; tick();
    chk("lat_v_a3", {31'b0, valid1}, 32'd1);
    chk("lat_d_a3", dout1, 32'h0303_0303);
    tick();

    // Same-address read-during-write.
    wr(7, 32'h1234_5678, 4'hF);
    we = 1'b1; addra = AW'(7); dina = 32'hFFFF_FFFF; bea = 4'b0011;
    reb = 1'b1; addrb = AW'(7);
    tick();
    idle();
    chk("rdw_old", dout0, 32'h1234_5678);
    tick();
    chk("rdw_first", dout1, 32'h1234_FFFF);
    rd(7);
    tick();

    // Out-of-range write must not land anywhere.
    wr(1010, 32'hDEAD_BEEF, 4'hF);
    for (int a = 0; a < DEPTH; a++) begin
      reb = 1'b1; addrb = AW'(a); tick();
    end
    idle();
    tick();

    // Randomized traffic, biased toward a small address window for collisions.
    for (int n = 0; n < 2000; n++) begin
      we    = 1'($urandom_range(0, 1));
      reb   = 1'($urandom_range(0, 1));
      bea   = 4'($urandom_range(0, 15));
      dina  = $urandom;
      addra = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 1023))
            : ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
            : AW'($urandom_range(0, DEPTH - 1));
      addrb = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(DEPTH, 1023))
            : ($urandom_range(0, 3) == 0) ? addra
            : AW'($urandom_range(0, 15));
      tick();
    end
    idle();
    tick(); tick();

    // Reset mid-read, then reset mid-clear at address 400, then full clear.
    wr(9, 32'hA5A5_5A5A, 4'hF);
    reb = 1'b1; addrb = AW'(9); tick(); tick();
    chk("pre_rst_valid1", {31'b0, valid1}, 32'd1);
    chk("pre_rst_dout1", dout1, 32'hA5A5_5A5A);
    idle();
    do_reset();
    run_clear(400);
    do_reset();
    run_clear(DEPTH);
    for (int n = 0; n < 8; n++) rd($urandom_range(0, DEPTH - 1));
    rd(9);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
